multdiv_sequencer: RTL

Controller that sequences the multicycle multiplier/divider from the execute stage of the 5-stage pipeline. It detects a `mul`/`div` in D/X and latches its operands. It issues a one-cycle start pulse, stalls the front of the pipeline until the unit reports ready or a watchdog expires, then presents a one-cycle result (or `rstatus` exception write) to the X/M latch. It also exports the in-flight destination register so bypass control can forward correctly.

---
 rtl/multdiv_sequencer_pkg.sv | 21 ++
 rtl/multdiv_sequencer_if.sv | 20 ++
 rtl/multdiv_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// rtl/multdiv_sequencer_pkg.sv - shared CPU types and constants for the multdiv sequencer
package multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [4:0]  REG_RSTATUS        = 5'd30;
  localparam logic [31:0] STATUS_MUL_DEFAULT = 32'd4;
  localparam logic [31:0] STATUS_DIV_DEFAULT = 32'd5;

  // rstatus value for an excepting or timed-out op; the ALU overflow path uses the same codes
  function automatic logic [31:0] status_code(input logic is_div,
                                              input logic [31:0] s_mul,
                                              input logic [31:0] s_div);
    return is_div ? s_div : s_mul;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// rtl/multdiv_sequencer_if.sv - operand/start/result bundle between sequencer and multdiv unit
interface multdiv_sequencer_if;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output md_opA, md_opB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  md_opA, md_opB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - issues mul/div to the multicycle unit, stalls the front end, returns one result strobe
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int          MAX_CYCLES = 40,
  parameter logic [31:0] STATUS_MUL = STATUS_MUL_DEFAULT,
  parameter logic [31:0] STATUS_DIV = STATUS_DIV_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dx_mul,
  input  logic                dx_div,
  input  logic [4:0]          dx_rd,
  input  logic [31:0]         dx_a,
  input  logic [31:0]         dx_b,
  input  logic                flush,
  multdiv_sequencer_if.master md,
  output logic                stall,
  output logic                busy,
  output logic [4:0]          multdiv_rd,
  output logic                res_valid,
  output logic [4:0]          res_rd,
  output logic [31:0]         res_data
);

  localparam int            CW      = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYCLES);

  md_state_e   state_q, state_d;
  logic [CW-1:0] count_q;
  logic [4:0]  rd_q;
  logic        is_div_q;
  logic [31:0] opa_q, opb_q;
  logic        mult_q, div_q;
  logic [4:0]  res_rd_q;
  logic [31:0] res_data_q;

  logic start_req;
  logic timeout;
  logic finish;
  logic exc;

  assign start_req = (dx_mul | dx_div) & ~flush;
  assign timeout   = (count_q == CNT_MAX);
  // A timeout reaches DONE without ready and is reported like an exception
  assign exc       = ~md.data_resultRDY | md.data_exception;

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    multdiv_rd = 5'd0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = BUSY;
          stall   = 1'b1;
        end
      end
      BUSY: begin
        stall      = 1'b1;
        multdiv_rd = rd_q;
        if (flush) begin
          state_d = IDLE;
        end else if (md.data_resultRDY || timeout) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE: begin
        multdiv_rd = res_rd_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_q       <= 5'd0;
      is_div_q   <= 1'b0;
      opa_q      <= 32'd0;
      opb_q      <= 32'd0;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      res_rd_q   <= 5'd0;
      res_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      res_rd_q   <= 5'd0;
      res_data_q <= 32'd0;
      if (state_q == IDLE && start_req) begin
        opa_q    <= dx_a;
        opb_q    <= dx_b;
        rd_q     <= dx_rd;
        is_div_q <= ~dx_mul;
        count_q  <= '0;
        mult_q   <= dx_mul;
        div_q    <= ~dx_mul;
      end
      if (state_q == BUSY && !timeout) begin
        count_q <= count_q + CW'(1);
      end
      if (finish) begin
        res_rd_q   <= exc ? REG_RSTATUS : rd_q;
        res_data_q <= exc ? status_code(is_div_q, STATUS_MUL, STATUS_DIV) : md.data_result;
      end
    end
  end

  assign md.md_opA   = opa_q;
  assign md.md_opB   = opb_q;
  assign md.ctrl_MULT = mult_q;
  assign md.ctrl_DIV  = div_q;

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_rd    = res_rd_q;
  assign res_data  = res_data_q;

endmodule
